// File: rtl/tensor_core_pkg.sv
// ============================================================================
// Module      : tensor_core_pkg
// Description : Shared types and helpers for the sequential tensor core.
//               - state_t      : FSM states IDLE / COMPUTE / DONE
//               - elem_off     : bit offset of element (i,j) in a packed
//                                DIM x DIM matrix, (0,0) in the MSBs
//               - acc_width    : accumulator width for the signed,
//                                saturating build (SEQ_TENSOR_CORE_SAT_EN)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tensor_core_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Row-major packing with element (0,0) occupying the most significant slot.
    function automatic int elem_off(input int i, input int j, input int dim, input int data_w);
        return ((dim - 1 - i) * dim + (dim - 1 - j)) * data_w;
    endfunction

    // Wide enough for DIM signed products plus a signed addend without overflow.
    function automatic int acc_width(input int dim, input int data_w);
        return 2 * data_w + $clog2(dim) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tensor_core_dot_product.sv
// ============================================================================
// Module      : tensor_core_dot_product
// Description : Combinational dot product of DIM element pairs plus an
//               optional addend, reduced to one DATA_W result.
//               Macro SEQ_TENSOR_CORE_SAT_EN:
//                 defined   - signed operands, wide accumulation, result
//                             saturated to the signed DATA_W range
//                 undefined - unsigned operands, result modulo 2^DATA_W
// Ports       : a_row   [DIM*DATA_W]  A[i][k] at slot k (k*DATA_W)
//               b_col   [DIM*DATA_W]  B[k][j] at slot k
//               addend  [DATA_W]      C[i][j]
//               add_en  [1]           include addend
//               result  [DATA_W]      reduced result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tensor_core_dot_product
    import tensor_core_pkg::*;
#(
    parameter int DIM    = 4,
    parameter int DATA_W = 8
) (
    input  logic [DIM*DATA_W-1:0] a_row,
    input  logic [DIM*DATA_W-1:0] b_col,
    input  logic [DATA_W-1:0]     addend,
    input  logic                  add_en,
    output logic [DATA_W-1:0]     result
);

`ifdef SEQ_TENSOR_CORE_SAT_EN
    localparam int c_ACC_W = acc_width(DIM, DATA_W);

    localparam logic signed [c_ACC_W-1:0] c_MAX =
        {{(c_ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_MIN =
        {{(c_ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [c_ACC_W-1:0] w_acc;

    always_comb begin
        w_acc = add_en ? c_ACC_W'($signed(addend)) : '0;
        for (int k = 0; k < DIM; k++) begin
            // Size casts of signed slices sign-extend before multiplying.
            w_acc = w_acc + c_ACC_W'($signed(a_row[k*DATA_W +: DATA_W]))
                          * c_ACC_W'($signed(b_col[k*DATA_W +: DATA_W]));
        end
    end

    always_comb begin
        if (w_acc > c_MAX) begin
            result = c_MAX[DATA_W-1:0];
        end else if (w_acc < c_MIN) begin
            result = c_MIN[DATA_W-1:0];
        end else begin
            result = w_acc[DATA_W-1:0];
        end
    end
`else
    // Only the low DATA_W bits survive the wrap, so accumulate at that width.
    logic [DATA_W-1:0] w_acc;

    always_comb begin
        w_acc = add_en ? addend : '0;
        for (int k = 0; k < DIM; k++) begin
            w_acc = w_acc + a_row[k*DATA_W +: DATA_W] * b_col[k*DATA_W +: DATA_W];
        end
    end

    assign result = w_acc;
`endif

endmodule

`default_nettype wire

// File: rtl/seq_tensor_core_mma.sv
// ============================================================================
// Module      : seq_tensor_core_mma
// Description : Sequential DIM x DIM matrix multiply-accumulate.
//               D = A*B (mode 0) or D = A*B + C (mode 1), one element per
//               cycle; operands captured at start, result published
//               atomically when the computation completes.
//               Macro SEQ_TENSOR_CORE_SAT_EN selects signed saturating
//               arithmetic (see tensor_core_dot_product).
// Ports       : clock_in                  clock, rising edge
//               reset_n_in                synchronous active-low reset
//               start_in                  request, accepted only in IDLE
//               mode_in                   0 = A*B, 1 = A*B + C
//               tensor_core_input1/2/3    matrices A, B, C
//               tensor_core_output        result D
//               busy_out                  high in COMPUTE and DONE
//               is_done_with_calculation  one-cycle completion pulse
//               output_valid_out          D holds a completed result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_tensor_core_mma
    import tensor_core_pkg::*;
#(
    parameter int DIM    = 4,
    parameter int DATA_W = 8
) (
    input  logic                      clock_in,
    input  logic                      reset_n_in,
    input  logic                      start_in,
    input  logic                      mode_in,
    input  logic [DIM*DIM*DATA_W-1:0] tensor_core_input1,
    input  logic [DIM*DIM*DATA_W-1:0] tensor_core_input2,
    input  logic [DIM*DIM*DATA_W-1:0] tensor_core_input3,
    output logic [DIM*DIM*DATA_W-1:0] tensor_core_output,
    output logic                      busy_out,
    output logic                      is_done_with_calculation,
    output logic                      output_valid_out
);

    localparam int c_MAT_W = DIM * DIM * DATA_W;
    localparam int c_CNT_W = $clog2(DIM * DIM) + 1;
    localparam int c_LAST  = DIM * DIM - 1;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_MAT_W-1:0]   r_a;
    logic [c_MAT_W-1:0]   r_b;
    logic [c_MAT_W-1:0]   r_c;
    logic                 r_mode;
    logic [c_MAT_W-1:0]   r_work;
    logic [c_MAT_W-1:0]   r_out;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_valid;

    int                   w_row;
    int                   w_col;
    logic [DIM*DATA_W-1:0] w_a_row;
    logic [DIM*DATA_W-1:0] w_b_col;
    logic [DATA_W-1:0]    w_addend;
    logic [DATA_W-1:0]    w_elem;

    // Operand selection for the element addressed by the counter. The counter
    // reaches DIM*DIM after the last write; clamp so indices stay in range.
    always_comb begin
        w_row = 0;
        w_col = 0;
        if (r_cnt <= c_CNT_W'(c_LAST)) begin
            w_row = int'(r_cnt) / DIM;
            w_col = int'(r_cnt) % DIM;
        end
        w_a_row = '0;
        w_b_col = '0;
        for (int k = 0; k < DIM; k++) begin
            w_a_row[k*DATA_W +: DATA_W] = r_a[elem_off(w_row, k, DIM, DATA_W) +: DATA_W];
            w_b_col[k*DATA_W +: DATA_W] = r_b[elem_off(k, w_col, DIM, DATA_W) +: DATA_W];
        end
        w_addend = r_c[elem_off(w_row, w_col, DIM, DATA_W) +: DATA_W];
    end

    tensor_core_dot_product #(
        .DIM    (DIM),
        .DATA_W (DATA_W)
    ) u_dot (
        .a_row  (w_a_row),
        .b_col  (w_b_col),
        .addend (w_addend),
        .add_en (r_mode),
        .result (w_elem)
    );

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_mode  <= 1'b0;
            r_work  <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_in) begin
                        r_a     <= tensor_core_input1;
                        r_b     <= tensor_core_input2;
                        r_c     <= tensor_core_input3;
                        r_mode  <= mode_in;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    r_work[elem_off(w_row, w_col, DIM, DATA_W) +: DATA_W] <= w_elem;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(c_LAST)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_out   <= r_work;
                    r_valid <= 1'b1;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tensor_core_output       = r_out;
    assign busy_out                 = r_busy;
    assign is_done_with_calculation = r_done;
    assign output_valid_out         = r_valid;

endmodule

`default_nettype wire
